line_ar_issuer: RTL and testbench

LINE_AR_ISSUER -- requirements
Module: line_ar_issuer

---
 rtl/line_ar_issuer.sv | 139 +++++++++++++
 tb/tb_line_ar_issuer.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_ar_issuer.sv
// Walks a frame line by line and turns offset/length descriptors into AXI read bursts.
// It tracks outstanding bursts and reports done once all data for the frame has returned.
module line_ar_issuer #(
    parameter int unsigned ADDR_W          = 32,
    parameter int unsigned DATA_W          = 64,
    parameter int unsigned MAX_OUTSTANDING = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [ADDR_W-1:0] stride_i,
    input  logic [15:0]       line_count_i,
    input  logic [ADDR_W-1:0] line_size_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              new_line_o,
    output logic [ADDR_W-1:0] line_size_o,
    input  logic [ADDR_W-1:0] offset_i,
    input  logic [7:0]        burst_len_i,
    input  logic              valid_i,
    input  logic              last_i,
    output logic              ready_o,
    output logic [ADDR_W-1:0] m_araddr_o,
    output logic [7:0]        m_arlen_o,
    output logic [2:0]        m_arsize_o,
    output logic [1:0]        m_arburst_o,
    output logic              m_arvalid_o,
    input  logic              m_arready_i,
    input  logic              m_rvalid_i,
    input  logic              m_rready_i,
    input  logic              m_rlast_i
);

    localparam int unsigned    CntW   = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CntW-1:0] MaxOut = CntW'(MAX_OUTSTANDING);
    localparam logic [2:0]      ArSize = 3'($clog2(DATA_W / 8));

    typedef enum logic [1:0] {StIdle, StLine, StBurst, StDrain} state_e;

    state_e            state_q;
    logic [15:0]       line_idx_q;
    logic [15:0]       line_count_q;
    logic [ADDR_W-1:0] line_base_q;
    logic [ADDR_W-1:0] stride_q;
    logic [ADDR_W-1:0] line_size_q;
    logic [ADDR_W-1:0] araddr_q;
    logic [7:0]        arlen_q;
    logic              arvalid_q;
    logic              ar_last_q;
    logic [CntW-1:0]   outstanding_q;

    logic ar_hs;
    logic r_done;
    logic desc_hs;

    assign ar_hs   = arvalid_q && m_arready_i;
    assign r_done  = m_rvalid_i && m_rready_i && m_rlast_i;
    assign desc_hs = valid_i && ready_o;

    assign ready_o     = (state_q == StBurst) && !arvalid_q && (outstanding_q < MaxOut);
    assign busy_o      = (state_q != StIdle);
    assign new_line_o  = (state_q == StLine);
    // Done is taken on the same edge that returns the FSM to idle, so it lasts one cycle.
    assign done_o      = (state_q == StDrain) && (outstanding_q == '0);
    assign line_size_o = line_size_q;
    assign m_araddr_o  = araddr_q;
    assign m_arlen_o   = arlen_q;
    assign m_arvalid_o = arvalid_q;
    assign m_arsize_o  = ArSize;
    assign m_arburst_o = 2'b01;

    // Simultaneous issue and completion cancel; a stray rlast at zero is ignored.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            outstanding_q <= '0;
        end else if (ar_hs && !r_done) begin
            outstanding_q <= outstanding_q + CntW'(1);
        end else if (r_done && !ar_hs && (outstanding_q != '0)) begin
            outstanding_q <= outstanding_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            line_idx_q   <= '0;
            line_count_q <= '0;
            line_base_q  <= '0;
            stride_q     <= '0;
            line_size_q  <= '0;
            araddr_q     <= '0;
            arlen_q      <= '0;
            arvalid_q    <= 1'b0;
            ar_last_q    <= 1'b0;
        end else begin
            if (desc_hs) begin
                araddr_q  <= line_base_q + offset_i;
                arlen_q   <= burst_len_i;
                ar_last_q <= last_i;
                arvalid_q <= 1'b1;
            end else if (ar_hs) begin
                arvalid_q <= 1'b0;
            end

            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        line_count_q <= line_count_i;
                        stride_q     <= stride_i;
                        line_size_q  <= line_size_i;
                        line_base_q  <= base_addr_i;
                        line_idx_q   <= '0;
                        state_q      <= (line_count_i == 16'd0) ? StDrain : StLine;
                    end
                end
                StLine: state_q <= StBurst;
                StBurst: begin
                    if (ar_hs && ar_last_q) begin
                        if (line_idx_q == line_count_q - 16'd1) begin
                            state_q <= StDrain;
                        end else begin
                            line_idx_q  <= line_idx_q + 16'd1;
                            line_base_q <= line_base_q + stride_q;
                            state_q     <= StLine;
                        end
                    end
                end
                StDrain: begin
                    if (outstanding_q == '0) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_line_ar_issuer.sv
// Self-checking bench for line_ar_issuer: directed frame table, hand-written corner sequences
// and randomized frames scored against an address-arithmetic reference model.
module tb_line_ar_issuer;

    localparam int MAXO = 2;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [31:0] base_addr_i, stride_i, line_size_i, offset_i;
    logic [15:0] line_count_i;
    logic [7:0]  burst_len_i;
    logic        valid_i, last_i;
    logic        busy_o, done_o, new_line_o, ready_o, m_arvalid_o;
    logic [31:0] line_size_o, m_araddr_o;
    logic [7:0]  m_arlen_o;
    logic [2:0]  m_arsize_o;
    logic [1:0]  m_arburst_o;
    logic        m_arready_i, m_rvalid_i, m_rready_i, m_rlast_i;

    line_ar_issuer #(
        .ADDR_W(32),
        .DATA_W(64),
        .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
        .base_addr_i(base_addr_i), .stride_i(stride_i),
        .line_count_i(line_count_i), .line_size_i(line_size_i),
        .busy_o(busy_o), .done_o(done_o), .new_line_o(new_line_o),
        .line_size_o(line_size_o), .offset_i(offset_i), .burst_len_i(burst_len_i),
        .valid_i(valid_i), .last_i(last_i), .ready_o(ready_o),
        .m_araddr_o(m_araddr_o), .m_arlen_o(m_arlen_o), .m_arsize_o(m_arsize_o),
        .m_arburst_o(m_arburst_o), .m_arvalid_o(m_arvalid_o), .m_arready_i(m_arready_i),
        .m_rvalid_i(m_rvalid_i), .m_rready_i(m_rready_i), .m_rlast_i(m_rlast_i)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;

    // Per-line descriptor list shared by every line of a frame.
    logic [31:0] d_off [3];
    logic [7:0]  d_len [3];
    int          d_n;

    logic [31:0] obs_addr [$];
    logic [7:0]  obs_len [$];
    int nl_cnt, done_cnt, viol, lat_bad, lsz_bad, unstable, early;

    typedef struct {
        logic [31:0] base;
        logic [31:0] stride;
        logic [15:0] lines;
        logic [31:0] size;
        int          n;
        logic [31:0] off0;
        logic [7:0]  len0;
        logic [31:0] off1;
        logic [7:0]  len1;
        int          exp_ars;
        logic [31:0] exp_last_addr;
        logic [7:0]  exp_last_len;
    } vec_t;

    vec_t vecs [5];

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        start_i = 1'b0; valid_i = 1'b0; last_i = 1'b0;
        offset_i = '0; burst_len_i = '0;
        m_arready_i = 1'b0; m_rvalid_i = 1'b0; m_rready_i = 1'b0; m_rlast_i = 1'b0;
    endtask

    // Acts as offset former, AXI slave and R-channel source for one whole frame.
    task automatic run_frame(input logic [31:0] base, input logic [31:0] stride,
                             input logic [15:0] lines, input logic [31:0] size,
                             input int ar_pct, input int r_pct);
        int cur_line, cur_d, pend, last_r;
        bit fin, have, rl, hold;
        logic [31:0] held_addr;
        logic [7:0]  held_len;
        obs_addr.delete(); obs_len.delete();
        nl_cnt = 0; done_cnt = 0; viol = 0; lat_bad = 0; lsz_bad = 0; unstable = 0; early = 0;
        cur_line = -1; cur_d = 0; pend = 0; last_r = -10; fin = 0; have = 0; hold = 0;
        held_addr = '0; held_len = '0;
        base_addr_i = base; stride_i = stride; line_count_i = lines; line_size_i = size;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
            if (hold && (!m_arvalid_o || m_araddr_o != held_addr || m_arlen_o != held_len))
                unstable++;
            if (done_o) begin
                done_cnt++;
                if (pend != 0) early++;
                if (cyc - last_r != 1) lat_bad++;
                fin = 1;
            end
            if (new_line_o) begin
                nl_cnt++; cur_line++; cur_d = 0; have = 1;
                if (line_size_o != size) lsz_bad++;
            end
            if (ready_o && pend >= MAXO) viol++;
            if (!fin) begin
                m_arready_i = ($urandom_range(0, 99) < ar_pct);
                rl = (pend > 0) && ($urandom_range(0, 99) < r_pct);
                m_rvalid_i = rl; m_rready_i = rl; m_rlast_i = rl;
                valid_i = have && (cur_d < d_n);
                offset_i = valid_i ? d_off[cur_d] : '0;
                burst_len_i = valid_i ? d_len[cur_d] : '0;
                last_i = valid_i && (cur_d == d_n - 1);
                hold = m_arvalid_o && !m_arready_i;
                held_addr = m_araddr_o; held_len = m_arlen_o;
                if (m_arvalid_o && m_arready_i) begin
                    obs_addr.push_back(m_araddr_o);
                    obs_len.push_back(m_arlen_o);
                    pend++;
                end
                if (rl) begin
                    pend--;
                    last_r = cyc;
                end
                if (valid_i && ready_o) begin
                    cur_d++;
                    if (cur_d == d_n) have = 0;
                end
                tick();
            end
        end
        idle_inputs();
    endtask

    task automatic frame_checks(input string tag, input logic [15:0] lines, input int exp_ars);
        check({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
        check({tag, "_new_lines"}, 64'(nl_cnt), 64'(lines));
        check({tag, "_ar_count"}, 64'(obs_addr.size()), 64'(exp_ars));
        check({tag, "_outstanding_cap"}, 64'(viol), 64'd0);
        check({tag, "_done_latency"}, 64'(lat_bad + early), 64'd0);
        check({tag, "_line_size"}, 64'(lsz_bad), 64'd0);
        check({tag, "_ar_stable"}, 64'(unstable), 64'd0);
    endtask

    initial begin
        idle_inputs();
        base_addr_i = '0; stride_i = '0; line_count_i = '0; line_size_i = '0;
        rst_i = 1'b1;
        tick();
        tick();
        check("reset_ctrl", {59'd0, busy_o, done_o, new_line_o, ready_o, m_arvalid_o}, 64'd0);
        check("reset_addr", {24'd0, m_araddr_o, m_arlen_o}, 64'd0);
        check("reset_line_size", 64'(line_size_o), 64'd0);
        rst_i = 1'b0;
        check("arsize_arburst", {59'd0, m_arsize_o, m_arburst_o}, {59'd0, 3'd3, 2'b01});

        // Directed frame table; addresses below were worked out by hand.
        vecs[0] = '{32'h1000, 32'h800, 16'd2, 32'd9, 1, 32'h0, 8'd9, 32'h0, 8'd0,
                    2, 32'h1800, 8'd9};
        vecs[1] = '{32'hFFFF_F000, 32'h800, 16'd3, 32'd3, 1, 32'h100, 8'd3, 32'h0, 8'd0,
                    3, 32'h0000_0100, 8'd3};
        vecs[2] = '{32'h2000, 32'h0, 16'd1, 32'd0, 1, 32'h40, 8'd0, 32'h0, 8'd0,
                    1, 32'h2040, 8'd0};
        vecs[3] = '{32'h0, 32'h1_0000, 16'd4, 32'd255, 1, 32'hFFFC, 8'd255, 32'h0, 8'd0,
                    4, 32'h3_FFFC, 8'd255};
        vecs[4] = '{32'h1_0000, 32'h1000, 16'd2, 32'd299, 2, 32'h0, 8'd255, 32'h800, 8'd44,
                    4, 32'h1_1800, 8'd44};
        for (int v = 0; v < 5; v++) begin
            d_n = vecs[v].n;
            d_off[0] = vecs[v].off0; d_len[0] = vecs[v].len0;
            d_off[1] = vecs[v].off1; d_len[1] = vecs[v].len1;
            d_off[2] = '0; d_len[2] = '0;
            run_frame(vecs[v].base, vecs[v].stride, vecs[v].lines, vecs[v].size,
                      (v == 0) ? 100 : 70, 60);
            frame_checks($sformatf("vec%0d", v), vecs[v].lines, vecs[v].exp_ars);
            if (obs_addr.size() > 0) begin
                check($sformatf("vec%0d_last_addr", v), 64'(obs_addr[$]), 64'(vecs[v].exp_last_addr));
                check($sformatf("vec%0d_last_len", v), 64'(obs_len[$]), 64'(vecs[v].exp_last_len));
                check($sformatf("vec%0d_first_addr", v), 64'(obs_addr[0]),
                      64'(vecs[v].base + vecs[v].off0));
            end
            tick();
        end

        // Outstanding limit, AR hold under backpressure, start ignored while busy.
        base_addr_i = 32'h4000; stride_i = 32'h100; line_count_i = 16'd1; line_size_i = 32'd7;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        check("stall_new_line", {62'd0, new_line_o, ready_o}, 64'd2);
        tick();
        check("stall_ready_first", 64'(ready_o), 64'd1);
        valid_i = 1'b1; offset_i = 32'h0; burst_len_i = 8'd1; last_i = 1'b0;
        tick();
        offset_i = 32'h20; burst_len_i = 8'd2;
        base_addr_i = 32'h9000; start_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("hold_ar_%0d", i), {22'd0, m_arvalid_o, ready_o, m_araddr_o, m_arlen_o},
                  {22'd0, 1'b1, 1'b0, 32'h4000, 8'd1});
            tick();
            start_i = 1'b0;
        end
        m_arready_i = 1'b1;
        tick();
        check("ready_after_hs", 64'(ready_o), 64'd1);
        tick();
        offset_i = 32'h40; burst_len_i = 8'd0; last_i = 1'b1;
        check("second_ar_addr", 64'(m_araddr_o), 64'h4020);
        tick();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("cap_stall_%0d", i), 64'(ready_o), 64'd0);
            tick();
        end
        m_rvalid_i = 1'b1; m_rready_i = 1'b1; m_rlast_i = 1'b1;
        tick();
        m_rvalid_i = 1'b0; m_rready_i = 1'b0; m_rlast_i = 1'b0;
        check("cap_release", 64'(ready_o), 64'd1);
        tick();
        valid_i = 1'b0; last_i = 1'b0;
        check("third_ar_addr", 64'(m_araddr_o), 64'h4040);
        tick();
        check("drain_busy", {62'd0, busy_o, done_o}, 64'd2);
        m_rvalid_i = 1'b1; m_rready_i = 1'b1; m_rlast_i = 1'b1;
        tick();
        check("drain_not_done", 64'(done_o), 64'd0);
        tick();
        m_rvalid_i = 1'b0; m_rready_i = 1'b0; m_rlast_i = 1'b0;
        check("drain_done", 64'(done_o), 64'd1);
        tick();
        check("after_done", {62'd0, busy_o, done_o}, 64'd0);
        // Stray completion while nothing is outstanding must not wrap the counter.
        m_rvalid_i = 1'b1; m_rready_i = 1'b1; m_rlast_i = 1'b1;
        tick();
        idle_inputs();

        // Empty frame.
        line_count_i = 16'd0; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        check("empty_done", {61'd0, done_o, new_line_o, busy_o}, 64'd5);
        tick();
        check("empty_idle", {62'd0, done_o, busy_o}, 64'd0);

        // Reset with an AR pending.
        base_addr_i = 32'h8000; stride_i = 32'h40; line_count_i = 16'd2; line_size_i = 32'd3;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        tick();
        valid_i = 1'b1; offset_i = 32'h10; burst_len_i = 8'd3;
        tick();
        valid_i = 1'b0;
        check("pre_reset_arvalid", 64'(m_arvalid_o), 64'd1);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check("midreset_ctrl", {59'd0, busy_o, done_o, new_line_o, ready_o, m_arvalid_o}, 64'd0);
        check("midreset_data", {24'd0, m_araddr_o, m_arlen_o}, 64'd0);
        check("midreset_line_size", 64'(line_size_o), 64'd0);
        idle_inputs();
        tick();

        // Randomized frames against the address-arithmetic model.
        for (int f = 0; f < 20; f++) begin
            logic [31:0] base, stride, size, e;
            logic [15:0] lines;
            int k;
            base = $urandom; stride = $urandom; size = $urandom;
            lines = 16'($urandom_range(1, 4));
            d_n = $urandom_range(1, 3);
            for (int d = 0; d < 3; d++) begin
                d_off[d] = $urandom;
                d_len[d] = 8'($urandom_range(0, 255));
            end
            run_frame(base, stride, lines, size, $urandom_range(30, 100), $urandom_range(20, 80));
            frame_checks($sformatf("rnd%0d", f), lines, int'(lines) * d_n);
            k = 0;
            for (int l = 0; l < int'(lines); l++) begin
                for (int d = 0; d < d_n; d++) begin
                    e = base + 32'(l) * stride + d_off[d];
                    if (k < obs_addr.size()) begin
                        check($sformatf("rnd%0d_ar%0d", f, k), {24'd0, obs_addr[k], obs_len[k]},
                              {24'd0, e, d_len[d]});
                    end
                    k++;
                end
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
